// File: rtl/oscill_nios_pio_led_pkg.sv
// oscill_nios_pio_led_pkg: register offsets and shared widths for the LED output PIO.
// Rev 1.0
`default_nettype none

package oscill_nios_pio_led_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_STATUS   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   localparam int PERIOD_W = 16;

   function automatic logic [31:0] status_word(input logic phase,
                                               input logic [PERIOD_W-1:0] cnt);
      return {cnt, 15'd0, phase};
   endfunction

endpackage

`default_nettype wire

// File: rtl/oscill_nios_pio_blink_timer.sv
// oscill_nios_pio_blink_timer: prescaled tick, half-period tick counter and blink phase.
// Rev 1.0
`default_nettype none

module oscill_nios_pio_blink_timer
   import oscill_nios_pio_led_pkg::*;
#(
   parameter int PRESCALE = 50000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PERIOD_W-1:0] period,
   input  logic                restart,
   output logic                phase,
   output logic [PERIOD_W-1:0] tick_cnt
);

   localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] prescaler;
   logic            tick;
   logic            period_zero;
   logic            half_done;

   assign tick        = (prescaler == PS_LAST);
   assign period_zero = (period == '0);
   assign half_done   = (tick_cnt == period - PERIOD_W'(1));

   // restart is the PERIOD write strobe; it outranks a coincident tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= '0;
         tick_cnt  <= '0;
         phase     <= 1'b1;
      end else if (restart) begin
         prescaler <= '0;
         tick_cnt  <= '0;
         phase     <= 1'b1;
      end else if (period_zero) begin
         phase     <= 1'b1;
      end else begin
         prescaler <= tick ? '0 : prescaler + PS_W'(1);
         if (tick) begin
            if (half_done) begin
               tick_cnt <= '0;
               phase    <= ~phase;
            end else begin
               tick_cnt <= tick_cnt + PERIOD_W'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/oscill_nios_pio_led.sv
// oscill_nios_pio_led: Avalon-MM output PIO driving LEDs, with set/clear aliases and per-bit blink.
// Rev 1.0
`default_nettype none

module oscill_nios_pio_led
   import oscill_nios_pio_led_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 10,
   parameter int                    PRESCALE    = 50000,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] blink_en;
   logic [PERIOD_W-1:0]   period;
   logic [PERIOD_W-1:0]   tick_cnt;
   logic                  phase;
   logic                  wr;
   logic                  period_wr;
   logic [DATA_WIDTH-1:0] wd;
   logic [31:0]           rd_mux;
   logic                  unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign period_wr    = wr && (address == ADDR_PERIOD);
   assign wd           = writedata[DATA_WIDTH-1:0];
   assign unused_wdata = &{1'b0, writedata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data     <= RESET_VALUE;
         blink_en <= '0;
         period   <= '0;
      end else if (wr) begin
         case (address)
            ADDR_DATA:     data     <= wd;
            ADDR_BLINK_EN: blink_en <= wd;
            ADDR_PERIOD:   period   <= writedata[PERIOD_W-1:0];
            ADDR_OUTSET:   data     <= data | wd;
            ADDR_OUTCLEAR: data     <= data & ~wd;
            default: ;
         endcase
      end
   end

   // The timer sees the old PERIOD on the write edge; restart covers that edge.
   oscill_nios_pio_blink_timer #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .period   (period),
      .restart  (period_wr),
      .phase    (phase),
      .tick_cnt (tick_cnt)
   );

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:     rd_mux[DATA_WIDTH-1:0] = data;
         ADDR_BLINK_EN: rd_mux[DATA_WIDTH-1:0] = blink_en;
         ADDR_PERIOD:   rd_mux[PERIOD_W-1:0]   = period;
         ADDR_STATUS:   rd_mux                 = status_word(phase, tick_cnt);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         out_port <= RESET_VALUE;
      end else begin
         readdata <= rd_mux;
         out_port <= data & ~(blink_en & {DATA_WIDTH{~phase}});
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_oscill_nios_pio_led.sv
// tb_oscill_nios_pio_led: scoreboard bench for the LED output PIO with PRESCALE=4.
// Rev 1.0
`default_nettype none

module tb_oscill_nios_pio_led;

   localparam int DW = 10;

   logic          clk;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [DW-1:0] out_port;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got;
   logic [31:0] exp;

   oscill_nios_pio_led #(
      .DATA_WIDTH  (DW),
      .PRESCALE    (4),
      .RESET_VALUE ('0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      @(posedge clk);
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      got = {22'd0, out_port};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_out_port: got 0x%08h want 0x%08h", got, exp); end
      got = readdata;
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_readdata: got 0x%08h want 0x%08h", got, exp); end
      reset_n = 1'b1;
      exp_q.push_back(32'h0);
      bus_read(3'd2, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_period: got 0x%08h want 0x%08h", got, exp); end
      exp_q.push_back(32'h1);
      bus_read(3'd3, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_status: got 0x%08h want 0x%08h", got, exp); end
   endtask

   task automatic test_data_access();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h2A5);
      bus_write(3'd0, 32'h2A5);
      got = {22'd0, out_port};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL data_out_early: got 0x%08h want 0x%08h", got, exp); end
      @(posedge clk);
      #1;
      got = {22'd0, out_port};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL data_out: got 0x%08h want 0x%08h", got, exp); end
      exp_q.push_back(32'h0000_02A5);
      bus_read(3'd0, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL data_read: got 0x%08h want 0x%08h", got, exp); end
   endtask

   task automatic test_set_clear();
      bus_write(3'd0, 32'h0F0);
      bus_write(3'd4, 32'hFFFF_F003);
      exp_q.push_back(32'h0F3);
      bus_read(3'd0, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL outset: got 0x%08h want 0x%08h", got, exp); end
      bus_write(3'd5, 32'h030);
      exp_q.push_back(32'h0C3);
      bus_read(3'd0, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL outclear: got 0x%08h want 0x%08h", got, exp); end
      exp_q.push_back(32'h0C3);
      got = {22'd0, out_port};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL setclr_out: got 0x%08h want 0x%08h", got, exp); end
      for (int a = 4; a <= 7; a++) begin
         exp_q.push_back(32'h0);
         bus_read(3'(a), got);
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL wo_read_%0d: got 0x%08h want 0x%08h", a, got, exp); end
      end
   endtask

   task automatic test_blink();
      bus_write(3'd0, 32'h3FF);
      bus_write(3'd1, 32'h001);
      bus_write(3'd2, 32'd2);
      // phase after restart edge + j is 1 for j/8 even; out_port lags phase by one edge
      for (int k = 1; k <= 12; k++)
         exp_q.push_back((((k - 1) / 8) % 2 == 0) ? 32'h3FF : 32'h3FE);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         got = {22'd0, out_port};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL blink_k%0d: got 0x%08h want 0x%08h", k, got, exp); end
      end
      bus_write(3'd2, 32'd0);
      for (int k = 0; k < 8; k++) exp_q.push_back(32'h3FF);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         got = {22'd0, out_port};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL blink_stop_%0d: got 0x%08h want 0x%08h", k, got, exp); end
      end
   endtask

   task automatic test_period_restart();
      bus_write(3'd2, 32'd2);
      repeat (12) @(posedge clk);
      #1;
      exp_q.push_back(32'h3FE);
      got = {22'd0, out_port};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL restart_pre: got 0x%08h want 0x%08h", got, exp); end
      bus_write(3'd2, 32'd3);
      exp_q.push_back(32'h0000_0001);
      bus_read(3'd3, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL restart_status: got 0x%08h want 0x%08h", got, exp); end
      address = 3'd3;
      for (int k = 2; k <= 16; k++) begin
         exp_q.push_back((k - 1 < 12) ? 32'h3FF : 32'h3FE);
         if (k == 10) exp_q.push_back(32'h0002_0001);
         @(posedge clk);
         #1;
         got = {22'd0, out_port};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL restart_k%0d: got 0x%08h want 0x%08h", k, got, exp); end
         if (k == 10) begin
            got = readdata;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL restart_tickcnt: got 0x%08h want 0x%08h", got, exp); end
         end
      end
   endtask

   task automatic test_reset_mid_blink();
      exp_q.push_back(32'h0001_0000);
      @(posedge clk);
      #1;
      got = readdata;
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL midrst_pre: got 0x%08h want 0x%08h", got, exp); end
      #2;
      reset_n = 1'b0;
      #1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      got = {22'd0, out_port};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL midrst_out: got 0x%08h want 0x%08h", got, exp); end
      got = readdata;
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL midrst_rd: got 0x%08h want 0x%08h", got, exp); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int a = 0; a <= 3; a++) begin
         exp_q.push_back((a == 3) ? 32'h1 : 32'h0);
         bus_read(3'(a), got);
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL midrst_reg%0d: got 0x%08h want 0x%08h", a, got, exp); end
      end
   endtask

   task automatic test_period_one();
      bus_write(3'd0, 32'h3FF);
      bus_write(3'd1, 32'h201);
      bus_write(3'd2, 32'd1);
      for (int k = 1; k <= 12; k++)
         exp_q.push_back((((k - 1) / 4) % 2 == 0) ? 32'h3FF : 32'h1FE);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         got = {22'd0, out_port};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL period1_k%0d: got 0x%08h want 0x%08h", k, got, exp); end
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      test_reset();
      test_data_access();
      test_set_clear();
      test_blink();
      test_period_restart();
      test_reset_mid_blink();
      test_period_one();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
